// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle controller and opcode decoder:
// state encoding, instruction classes, opcode constants and ALU-op codes.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } cls_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ and B carry immediate bits in the low opcode field; only the prefix matters.
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

endpackage

// File: rtl/arm_opcode_decoder.sv
// Combinational opcode (instruction[31:21]) to instruction-class decoder,
// shared by the multicycle controller and the single-cycle control unit.
module arm_opcode_decoder
  import arm_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output cls_t        cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode[10:3] == OP_CBZ_PFX) begin
      cls = CLS_CBZ;
    end else if (opcode[10:5] == OP_B_PFX) begin
      cls = CLS_B;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_RTYPE;
        OP_LDUR:                        cls = CLS_LDUR;
        OP_STUR:                        cls = CLS_STUR;
        default:                        cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM for the LEGv8 datapath with handshaked memories.
// Optional handshake watchdog enabled by defining MEM_TIMEOUT_EN.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] opcode,
  input  logic        zero_alu,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_to_loc,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state_q, state_d;
  cls_t   cls_q, cls_dec;
  logic   illegal_q;
  logic   wait_expired;

  arm_opcode_decoder u_dec (
    .opcode (opcode),
    .cls    (cls_dec)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout_q;

  assign waiting      = ((state_q == ST_FETCH) && !imem_ready) ||
                        ((state_q == ST_MEM)   && !dmem_ready);
  // A ready in the limit cycle clears waiting, so the handshake completes.
  assign wait_expired = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_RTYPE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        cls_q <= cls_dec;
        if (cls_dec == CLS_ILLEGAL) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        state_d = (cls_dec == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_RTYPE:          state_d = ST_WB;
          CLS_LDUR, CLS_STUR: state_d = ST_MEM;
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset_n is asserted.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_to_loc = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_RTYPE: begin
              alu_op  = ALU_RTYPE;
              alu_src = 1'b0;
            end
            CLS_LDUR: begin
              alu_op  = ALU_ADD;
              alu_src = 1'b1;
            end
            CLS_STUR: begin
              alu_op     = ALU_ADD;
              alu_src    = 1'b1;
              reg_to_loc = 1'b1;
            end
            CLS_CBZ: begin
              alu_op     = ALU_PASSB;
              reg_to_loc = 1'b1;
              pc_write   = 1'b1;
              pc_src     = zero_alu;
            end
            CLS_B: begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          alu_op     = ALU_ADD;
          alu_src    = 1'b1;
          reg_to_loc = (cls_q == CLS_STUR);
          if (cls_q == CLS_LDUR) begin
            dmem_read = 1'b1;
          end else begin
            dmem_write = 1'b1;
            pc_write   = dmem_ready;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LDUR);
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, per-instruction
// trace model with random waits/opcodes, reset and halt corner cases.
module tb_multicycle_controller;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        reset_n;
  logic [10:0] opcode;
  logic        zero_alu, imem_ready, dmem_ready;
  logic        imem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg, reg_write, dmem_read, dmem_write;
  logic [2:0]  state;
  logic        illegal, timeout;

  multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero_alu   (zero_alu),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_to_loc (reg_to_loc),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .state      (state),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_to_loc;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       dmem_read;
    logic       dmem_write;
    logic [2:0] st;
    logic       ill;
    logic       tmo;
  } out_t;

  typedef struct {
    logic [10:0] op;
    logic        ir;
    logic        dr;
    logic        z;
    out_t        exp;
  } vec_t;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  out_t act;
  assign act = {imem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src, alu_op,
                mem_to_reg, reg_write, dmem_read, dmem_write, state, illegal, timeout};

  vec_t q[$];
  vec_t add_tab[5];
  int   errors = 0;
  int   checks = 0;
  logic m_ill = 1'b0;
  logic m_to  = 1'b0;

  // strobes s = {imem_req,ir_write,pc_write,pc_src,reg_to_loc,alu_src,alu_op,mem_to_reg,reg_write,dmem_read,dmem_write}
  function automatic out_t mk(logic [2:0] st, logic [11:0] s);
    return {s, st, m_ill, m_to};
  endfunction

  function automatic int classify(logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [10:0] rand_op(int c);
    logic [10:0] r;
    r = 11'($urandom);
    case (c)
      C_R: begin
        case ($urandom_range(0, 3))
          0: r = 11'b10001011000;
          1: r = 11'b11001011000;
          2: r = 11'b10001010000;
          default: r = 11'b10101010000;
        endcase
      end
      C_LD:  r = 11'b11111000010;
      C_ST:  r = 11'b11111000000;
      C_CBZ: r = {8'b10110100, 3'($urandom)};
      C_B:   r = {6'b000101, 5'($urandom)};
      default: r = 11'b11111111111;
    endcase
    return r;
  endfunction

  task automatic push(input logic [10:0] op, input logic ir, input logic dr,
                      input logic z, input out_t o);
    vec_t v;
    v.op = op; v.ir = ir; v.dr = dr; v.z = z; v.exp = o;
    q.push_back(v);
  endtask

  task automatic check(input string tag, input out_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", tag, $time, act, want);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    opcode = v.op; imem_ready = v.ir; dmem_ready = v.dr; zero_alu = v.z;
    @(negedge clk);
    check(tag, v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string tag);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(v, tag);
    end
  endtask

  // Expected cycle trace of one instruction: wi FETCH waits, wd data-memory waits.
  task automatic gen_instr(input logic [10:0] op, input int wi, input int wd, input logic z);
    int   c;
    out_t o;
    c = classify(op);
    for (int i = 0; i < wi; i++) begin
      o = mk(3'd0, '0); o.imem_req = 1'b1;
      push(11'($urandom), 1'b0, 1'($urandom), 1'($urandom), o);
    end
    o = mk(3'd0, '0); o.imem_req = 1'b1; o.ir_write = 1'b1;
    push(11'($urandom), 1'b1, 1'($urandom), 1'($urandom), o);
    push(op, 1'($urandom), 1'($urandom), 1'($urandom), mk(3'd1, '0));
    if (c == C_ILL) begin
      m_ill = 1'b1;
      for (int i = 0; i < 4; i++) push(11'($urandom), 1'b1, 1'($urandom), 1'($urandom), mk(3'd7, '0));
      return;
    end
    o = mk(3'd2, '0);
    case (c)
      C_R:   o.alu_op = 2'b10;
      C_LD:  o.alu_src = 1'b1;
      C_ST:  begin o.alu_src = 1'b1; o.reg_to_loc = 1'b1; end
      C_CBZ: begin o.alu_op = 2'b01; o.reg_to_loc = 1'b1; o.pc_write = 1'b1; o.pc_src = z; end
      default: begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
    endcase
    push(11'($urandom), 1'($urandom), 1'($urandom), z, o);
    if (c == C_LD || c == C_ST) begin
      for (int j = 0; j <= wd; j++) begin
        o = mk(3'd3, '0); o.alu_src = 1'b1; o.reg_to_loc = (c == C_ST);
        if (c == C_LD) o.dmem_read = 1'b1;
        else begin o.dmem_write = 1'b1; o.pc_write = (j == wd); end
        push(11'($urandom), 1'($urandom), (j == wd), 1'($urandom), o);
      end
    end
    if (c == C_R || c == C_LD) begin
      o = mk(3'd4, '0); o.reg_write = 1'b1; o.mem_to_reg = (c == C_LD); o.pc_write = 1'b1;
      push(11'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), o);
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero_alu = 1'b1;
    m_ill = 1'b0; m_to = 1'b0;
    #1;
    check(tag, mk(3'd0, '0));
    @(posedge clk);
    #1;
    check(tag, mk(3'd0, '0));
    reset_n = 1'b1;
  endtask

  initial begin
    add_tab[0] = '{11'b10001011000, 1'b1, 1'b1, 1'b0, mk(3'd0, 12'b1100_0000_0000)};
    add_tab[1] = '{11'b10001011000, 1'b1, 1'b1, 1'b0, mk(3'd1, 12'b0000_0000_0000)};
    add_tab[2] = '{11'b10001011000, 1'b1, 1'b1, 1'b0, mk(3'd2, 12'b0000_0010_0000)};
    add_tab[3] = '{11'b10001011000, 1'b1, 1'b1, 1'b0, mk(3'd4, 12'b0010_0000_0100)};
    add_tab[4] = '{11'b10001011000, 1'b0, 1'b1, 1'b0, mk(3'd0, 12'b1000_0000_0000)};

    reset_n = 1'b0; opcode = '0; zero_alu = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse("reset");

    for (int i = 0; i < 5; i++) apply(add_tab[i], "add_tab");

    gen_instr(11'b11111000010, 0, 3, 1'b0);
    run_q("ldur_wait3");
    gen_instr({8'b10110100, 3'd5}, 1, 0, 1'b1);
    gen_instr({8'b10110100, 3'd2}, 0, 0, 1'b0);
    run_q("cbz");
    gen_instr({6'b000101, 5'd9}, 2, 0, 1'b0);
    gen_instr(11'b11111000000, 0, 0, 1'b0);
    run_q("b_stur");

    for (int n = 0; n < 40; n++) begin
      gen_instr(rand_op($urandom_range(0, 4)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom));
      run_q("random");
    end

    // STUR aborted by reset in the middle of its data-memory wait.
    push(11'($urandom), 1'b1, 1'b0, 1'b0, mk(3'd0, 12'b1100_0000_0000));
    push(11'b11111000000, 1'b0, 1'b0, 1'b0, mk(3'd1, '0));
    push(11'($urandom), 1'b0, 1'b1, 1'b0, mk(3'd2, 12'b0000_1100_0000));
    push(11'($urandom), 1'b0, 1'b0, 1'b0, mk(3'd3, 12'b0000_1100_0001));
    push(11'($urandom), 1'b0, 1'b0, 1'b0, mk(3'd3, 12'b0000_1100_0001));
    run_q("stur_pre");
    reset_pulse("stur_abort");
    gen_instr(rand_op(C_R), 0, 0, 1'b0);
    run_q("after_abort");

    gen_instr(11'b11111111111, 1, 0, 1'b0);
    run_q("illegal");
    reset_pulse("illegal_reset");
    gen_instr(rand_op(C_B), 0, 0, 1'b0);
    run_q("after_illegal");

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++) push(11'($urandom), 1'b0, 1'b1, 1'b0, mk(3'd0, 12'b1000_0000_0000));
    m_to = 1'b1;
    for (int i = 0; i < 3; i++) push(11'($urandom), 1'b1, 1'b1, 1'b0, mk(3'd7, '0));
    run_q("fetch_timeout");
    reset_pulse("timeout_reset");
    gen_instr(rand_op(C_B), TO - 1, 0, 1'b0);
    run_q("fetch_ready_at_limit");
    gen_instr(11'b11111000010, 0, TO - 1, 1'b0);
    run_q("mem_ready_at_limit");
    push(11'($urandom), 1'b1, 1'b0, 1'b0, mk(3'd0, 12'b1100_0000_0000));
    push(11'b11111000010, 1'b0, 1'b0, 1'b0, mk(3'd1, '0));
    push(11'($urandom), 1'b0, 1'b0, 1'b0, mk(3'd2, 12'b0000_0100_0000));
    for (int i = 0; i < TO; i++) push(11'($urandom), 1'b1, 1'b0, 1'b0, mk(3'd3, 12'b0000_0100_0010));
    run_q("mem_wait");
    m_to = 1'b1;
    push(11'($urandom), 1'b1, 1'b1, 1'b0, mk(3'd7, '0));
    run_q("mem_timeout");
`else
    gen_instr(11'b11111000010, 20, 20, 1'b0);
    run_q("long_wait");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
